// File: rtl/text_buffer_16x16.sv
// Writable ROWS x COLS character buffer: handshaked byte-stream writes at an auto-advancing cursor,
// registered read port. Optional blinking cursor overlay is enabled by defining TEXT_CURSOR_EN.
module text_buffer_16x16 #(
  parameter int unsigned COLS      = 16,
  parameter int unsigned ROWS      = 16,
  parameter int unsigned CODE_W    = 7,
  parameter int unsigned BLINK_DIV = 25_000_000,
  localparam int unsigned COL_W    = $clog2(COLS),
  localparam int unsigned ROW_W    = $clog2(ROWS),
  localparam int unsigned XY_W     = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ready,
  input  logic [XY_W-1:0]   char_xy,
  output logic [CODE_W-1:0] char_code,
  output logic [XY_W-1:0]   cursor_xy,
  output logic              busy
);

  localparam int unsigned DEPTH = ROWS * COLS;
  localparam int unsigned AW    = $clog2(DEPTH);

  localparam logic [CODE_W-1:0] SPACE   = CODE_W'('h20);
  localparam logic [CODE_W-1:0] TILDE   = CODE_W'('h7E);
  localparam logic [CODE_W-1:0] NEWLINE = CODE_W'('h0A);
  localparam logic [CODE_W-1:0] BKSP    = CODE_W'('h08);
  localparam logic [CODE_W-1:0] FORMFD  = CODE_W'('h0C);

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [AW-1:0]    SWEEP_LAST = AW'(DEPTH - 1);

  if (COLS < 2 || ROWS < 2 || BLINK_DIV < 1) begin : g_bad_params
    $error("text_buffer_16x16: COLS/ROWS must be >= 2 and BLINK_DIV >= 1");
  end

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     sweep_q, sweep_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CODE_W-1:0] char_code_q, char_code_d;

  logic [CODE_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [CODE_W-1:0] mem_wdata;

  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic              rd_in_range;
  logic [AW-1:0]     rd_idx;
  logic [AW-1:0]     cur_idx;

  assign wr_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign cursor_xy = {row_q, col_q};
  assign char_code = char_code_q;

  assign rd_row      = char_xy[XY_W-1:COL_W];
  assign rd_col      = char_xy[COL_W-1:0];
  assign rd_in_range = (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);
  assign rd_idx      = rd_in_range ? AW'(32'(rd_row) * COLS + 32'(rd_col)) : '0;
  assign cur_idx     = AW'(32'(row_q) * COLS + 32'(col_q));

`ifdef TEXT_CURSOR_EN
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`endif

  // Control FSM: clear sweep plus cursor handling of accepted codes.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    row_d     = row_q;
    col_d     = col_q;
    mem_we    = 1'b0;
    mem_waddr = cur_idx;
    mem_wdata = wr_code;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = SPACE;
        if (sweep_q == SWEEP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          sweep_d = sweep_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (wr_valid) begin
          if (wr_code >= SPACE && wr_code <= TILDE) begin
            mem_we = 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (wr_code == NEWLINE) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          end else if (wr_code == BKSP) begin
            if (col_q != '0) begin
              col_d = col_q - COL_W'(1);
            end else if (row_q != '0) begin
              col_d = COL_LAST;
              row_d = row_q - ROW_W'(1);
            end
          end else if (wr_code == FORMFD) begin
            row_d   = '0;
            col_d   = '0;
            sweep_d = '0;
            state_d = ST_CLEAR;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    if (state_q == ST_CLEAR || !rd_in_range) begin
      char_code_d = SPACE;
`ifdef TEXT_CURSOR_EN
    end else if (blink_phase_q && char_xy == cursor_xy) begin
      char_code_d = CODE_W'('h5F);
`endif
    end else begin
      char_code_d = mem[rd_idx];
    end
  end

  // Read-first: the read above sees the content from before this edge's write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      sweep_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      char_code_q <= SPACE;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      row_q       <= row_d;
      col_q       <= col_d;
      char_code_q <= char_code_d;
    end
  end

endmodule

// File: tb/tb_text_buffer_16x16.sv
// Directed bench for text_buffer_16x16 (default build): reads are scored through an expected-value queue.
module tb_text_buffer_16x16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_code = '0;
  logic       wr_ready;
  logic [7:0] char_xy = '0;
  logic [6:0] char_code;
  logic [7:0] cursor_xy;
  logic       busy;

  text_buffer_16x16 #(.COLS(16), .ROWS(16), .CODE_W(7)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_code(wr_code), .wr_ready(wr_ready),
    .char_xy(char_xy), .char_code(char_code), .cursor_xy(cursor_xy), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [6:0] exp;
  } rd_t;

  rd_t        exp_q[$];
  logic [6:0] mem_m [256];
  int         crow = 0;
  int         ccol = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    rd_t r;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk($sformatf("read@%02h", r.addr), 32'(char_code), 32'(r.exp));
    end
  endtask

  function automatic logic [7:0] cur_m();
    return 8'(crow * 16 + ccol);
  endfunction

  function automatic void apply_m(input logic [6:0] c);
    if (c >= 7'h20 && c <= 7'h7E) begin
      mem_m[crow * 16 + ccol] = c;
      ccol++;
      if (ccol == 16) begin
        ccol = 0;
        crow = (crow + 1) % 16;
      end
    end else if (c == 7'h0A) begin
      ccol = 0;
      crow = (crow + 1) % 16;
    end else if (c == 7'h08) begin
      if (ccol > 0) ccol--;
      else if (crow > 0) begin
        crow--;
        ccol = 15;
      end
    end else if (c == 7'h0C) begin
      crow = 0;
      ccol = 0;
      for (int i = 0; i < 256; i++) mem_m[i] = 7'h20;
    end
  endfunction

  task automatic wr(input logic [6:0] c);
    chk("wr_ready_at_write", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_code  = c;
    tick();
    wr_valid = 1'b0;
    apply_m(c);
  endtask

  // Write and read the cursor cell in the same cycle; the old content must come back.
  task automatic wr_rd_same(input logic [6:0] c);
    char_xy = cur_m();
    exp_q.push_back('{cur_m(), mem_m[crow * 16 + ccol]});
    wr(c);
  endtask

  task automatic rd(input logic [7:0] a);
    char_xy = a;
    exp_q.push_back('{a, mem_m[a]});
    tick();
  endtask

  task automatic rd_const(input logic [7:0] a, input logic [6:0] e);
    char_xy = a;
    exp_q.push_back('{a, e});
    tick();
  endtask

  // Counts cycles until wr_ready, reading random cells (always space while busy).
  task automatic wait_clear(input string tag);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 2000) begin
      chk("busy_during_clear", 32'(busy), 32'd1);
      char_xy = 8'($urandom_range(0, 255));
      exp_q.push_back('{char_xy, 7'h20});
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd256);
    chk("busy_after_clear", 32'(busy), 32'd0);
    for (int i = 0; i < 256; i++) mem_m[i] = 7'h20;
  endtask

  task automatic chk_reset_vals();
    chk("rst_char_code", 32'(char_code), 32'h20);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cursor", 32'(cursor_xy), 32'd0);
  endtask

  initial begin
    string msg;
    for (int i = 0; i < 256; i++) mem_m[i] = 7'h20;

    // Reset state and the initial clear sweep
    #1 rst = 1'b1;
    #1 chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    rst = 1'b0;
    wait_clear("reset_clear_len");
    for (int a = 0; a < 256; a++) rd_const(8'(a), 7'h20);

    // "By" newline "Dawid"
    msg = "By";
    for (int i = 0; i < msg.len(); i++) wr(7'(msg[i]));
    wr(7'h0A);
    msg = "Dawid";
    for (int i = 0; i < msg.len(); i++) wr(7'(msg[i]));
    chk("cursor_after_text", 32'(cursor_xy), 32'h15);
    rd_const(8'h00, 7'h42);
    rd_const(8'h01, 7'h79);
    rd_const(8'h10, 7'h44);
    rd_const(8'h14, 7'h64);
    rd(8'h11);

    // Same-cycle write/read returns old data, next-cycle read returns new
    wr_rd_same(7'h5A);
    rd_const(8'h15, 7'h5A);
    chk("cursor_after_z", 32'(cursor_xy), 32'h16);
    wr(7'h01);
    wr(7'h7F);
    chk("cursor_after_ignored", 32'(cursor_xy), 32'h16);
    rd_const(8'h16, 7'h20);

    // Clear mid-text
    wr(7'h0C);
    chk("ready_low_after_ff", 32'(wr_ready), 32'd0);
    wait_clear("ff_clear_len");
    chk("cursor_after_clear", 32'(cursor_xy), 32'd0);
    rd_const(8'h00, 7'h20);
    rd_const(8'h15, 7'h20);

    // Fill every cell; cursor wraps, 257th code overwrites cell 0
    for (int i = 0; i < 256; i++) wr(7'(8'h21 + (i % 94)));
    chk("cursor_wrap", 32'(cursor_xy), 32'h00);
    wr(7'h40);
    chk("cursor_after_257", 32'(cursor_xy), 32'h01);
    rd_const(8'h00, 7'h40);
    for (int a = 1; a < 256; a++) rd(8'(a));

    // Backspace saturation and row step-back
    wr(7'h08);
    chk("bksp_to_0", 32'(cursor_xy), 32'h00);
    wr(7'h08);
    chk("bksp_saturate", 32'(cursor_xy), 32'h00);
    wr(7'h0A);
    chk("newline_row1", 32'(cursor_xy), 32'h10);
    wr(7'h08);
    chk("bksp_prev_row", 32'(cursor_xy), 32'h0F);
    rd(8'h0F);
    rd(8'h10);
    for (int i = 0; i < 15; i++) wr(7'h0A);
    chk("newline_last_row", 32'(cursor_xy), 32'hF0);
    wr(7'h0A);
    chk("newline_wrap", 32'(cursor_xy), 32'h00);

    // Reset in the middle of a clear sweep
    wr(7'h0C);
    for (int i = 0; i < 100; i++) rd_const(8'(i), 7'h20);
    rst = 1'b1;
    #1 chk_reset_vals();
    repeat (2) @(posedge clk);
    #1 chk_reset_vals();
    rst = 1'b0;
    wait_clear("reset_midsweep_len");
    chk("cursor_after_reset", 32'(cursor_xy), 32'd0);
    rd_const(8'h00, 7'h20);
    rd_const(8'hFF, 7'h20);
    wr(7'h31);
    rd_const(8'h00, 7'h31);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
